// File: rtl/seq_mul_add_check.sv
// Sequential shift-and-add multiplier: dividend = quotient * divisor + remainder.
// Used to cross-check the restoring divider and as a standalone multiply-accumulate unit.
module seq_mul_add_check #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               go,
    input  logic [WIDTH-1:0]   quotient,
    input  logic [WIDTH-1:0]   divisor,
    input  logic [WIDTH:0]     remainder,
    output logic [2*WIDTH:0]   dividend,
    output logic               in_range,
    output logic               rem_ok,
    output logic               busy,
    output logic               done
);

    localparam int unsigned AccW = 2 * WIDTH + 1;
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWaitRel,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [AccW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplr_q, mplr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              rem_ok_nx_q, rem_ok_nx_d;
    logic [AccW-1:0]   dividend_q, dividend_d;
    logic              in_range_q, in_range_d;
    logic              rem_ok_q, rem_ok_d;
    logic              done_q, done_d;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplr_d      = mplr_q;
        cnt_d       = cnt_q;
        rem_ok_nx_d = rem_ok_nx_q;
        dividend_d  = dividend_q;
        in_range_d  = in_range_q;
        rem_ok_d    = rem_ok_q;
        done_d      = 1'b0;

        case (state_q)
            StIdle: begin
                if (go) begin
                    state_d = StWaitRel;
                end
            end
            StWaitRel: begin
                // Operands are sampled on the release edge of go, as the divider does.
                if (!go) begin
                    acc_d       = AccW'(remainder);
                    mplr_d      = quotient;
                    mcand_d     = AccW'(divisor);
                    cnt_d       = '0;
                    rem_ok_nx_d = (divisor != '0) && (remainder < {1'b0, divisor});
                    state_d     = StRun;
                end
            end
            StRun: begin
                if (mplr_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                dividend_d = acc_q;
                in_range_d = (acc_q[AccW-1:WIDTH] == '0);
                rem_ok_d   = rem_ok_nx_q;
                done_d     = 1'b1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplr_q      <= '0;
            cnt_q       <= '0;
            rem_ok_nx_q <= 1'b0;
            dividend_q  <= '0;
            in_range_q  <= 1'b0;
            rem_ok_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplr_q      <= mplr_d;
            cnt_q       <= cnt_d;
            rem_ok_nx_q <= rem_ok_nx_d;
            dividend_q  <= dividend_d;
            in_range_q  <= in_range_d;
            rem_ok_q    <= rem_ok_d;
            done_q      <= done_d;
        end
    end

    assign dividend = dividend_q;
    assign in_range = in_range_q;
    assign rem_ok   = rem_ok_q;
    assign done     = done_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_seq_mul_add_check.sv
// Directed bench for seq_mul_add_check (WIDTH=4) with hand-computed results.
module tb_seq_mul_add_check;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             resetn;
    logic             go;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   remainder;
    logic [2*WIDTH:0] dividend;
    logic             in_range;
    logic             rem_ok;
    logic             busy;
    logic             done;

    int n_vec;
    int n_err;

    seq_mul_add_check #(
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .go       (go),
        .quotient (quotient),
        .divisor  (divisor),
        .remainder(remainder),
        .dividend (dividend),
        .in_range (in_range),
        .rem_ok   (rem_ok),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Press go for hold_cycles, release, then wait for done and check the result.
    // Outputs are sampled 1 time unit after each rising edge.
    task automatic run_op(input string tag, input int q, input int d, input int r,
                          input int hold_cycles, input bit scramble, input int prev_div,
                          input int exp_div, input int exp_inr, input int exp_rok);
        int  lat;
        bit  hold_ok;
        bit  wait_ok;
        @(negedge clk);
        quotient  = WIDTH'(q);
        divisor   = WIDTH'(d);
        remainder = (WIDTH + 1)'(r);
        go        = 1'b1;
        wait_ok   = 1'b1;
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1 || done !== 1'b0) wait_ok = 1'b0;
        end
        check_val({tag, " busy_while_go"}, 32'(wait_ok), 32'd1);
        @(negedge clk);
        go = 1'b0;
        @(posedge clk);  // capture edge
        #1;
        hold_ok = 1'b1;
        lat     = 0;
        for (int i = 1; i <= 12; i++) begin
            if (scramble) begin
                quotient  = WIDTH'($urandom);
                divisor   = WIDTH'($urandom);
                remainder = (WIDTH + 1)'($urandom);
            end
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            if (dividend !== (2 * WIDTH + 1)'(prev_div)) hold_ok = 1'b0;
        end
        check_val({tag, " latency"}, 32'(lat), 32'd5);
        check_val({tag, " dividend"}, 32'(dividend), 32'(exp_div));
        check_val({tag, " in_range"}, 32'(in_range), 32'(exp_inr));
        check_val({tag, " rem_ok"}, 32'(rem_ok), 32'(exp_rok));
        check_val({tag, " hold_prev"}, 32'(hold_ok), 32'd1);
        @(posedge clk);
        #1;
        check_val({tag, " done_pulse"}, 32'(done), 32'd0);
        check_val({tag, " hold_after"}, 32'(dividend), 32'(exp_div));
    endtask

    initial begin
        bit no_done;
        n_vec     = 0;
        n_err     = 0;
        resetn    = 1'b0;
        go        = 1'b0;
        quotient  = '0;
        divisor   = '0;
        remainder = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst dividend", 32'(dividend), 32'd0);
        check_val("rst in_range", 32'(in_range), 32'd0);
        check_val("rst rem_ok", 32'(rem_ok), 32'd0);
        check_val("rst done", 32'(done), 32'd0);
        check_val("rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_op("q3d4r1",    3,  4,  1, 1, 1'b0,   0,  13, 1, 1);
        run_op("q15d15r31", 15, 15, 31, 1, 1'b0,  13, 256, 0, 0);
        run_op("q15d15r0",  15, 15, 0,  1, 1'b0, 256, 225, 0, 1);
        run_op("q7d0r5",    7,  0,  5,  1, 1'b0, 225,   5, 1, 0);
        run_op("q0d9r2",    0,  9,  2,  1, 1'b0,   5,   2, 1, 1);
        run_op("hold10",    5,  2,  1, 10, 1'b0,   2,  11, 1, 1);
        run_op("scramble",  6,  3,  2,  1, 1'b1,  11,  20, 0, 1);

        // Abort mid-RUN with a one-edge reset.
        @(negedge clk);
        quotient  = 4'd9;
        divisor   = 4'd7;
        remainder = 5'd6;
        go        = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(posedge clk);  // capture
        @(posedge clk);  // RUN step 1
        #1;
        resetn = 1'b0;
        @(posedge clk);  // reset edge during RUN step 2
        #1;
        resetn = 1'b1;
        check_val("abort busy", 32'(busy), 32'd0);
        check_val("abort dividend", 32'(dividend), 32'd0);
        no_done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) no_done = 1'b0;
        end
        check_val("abort no_done", 32'(no_done), 32'd1);
        check_val("abort dividend_held", 32'(dividend), 32'd0);

        run_op("after_rst", 9,  7,  6, 1, 1'b0,  0, 69, 0, 1);
        run_op("b2b_first", 2,  5,  4, 1, 1'b0, 69, 14, 1, 1);
        run_op("b2b_second", 1, 1,  0, 1, 1'b0, 14,  1, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
